imem_loader: RTL and testbench

- Writer-side counterpart to the CPU's instruction fetch.
- Receives a byte stream from a host or debug link and assembles it into 32-bit words. Writes those words sequentially into the instruction memory write port.
- Holds the Mips core in reset until a complete program image has been written. This replaces simulation-only hex preloading with a synthesizable boot path.

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words, writes
// them sequentially into the instruction memory and holds the CPU in reset
// until a complete program image has been loaded.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a 32-bit running sum of the written words is compared with
//   one trailing checksum word; a mismatch sets Chk_Err and keeps the CPU in
//   reset. When undefined there is no CHECK state and Chk_Err is tied low.
//
// Ports:
//   Clk        system clock (rising edge)
//   Reset      asynchronous active-low reset
//   Load_Start one-cycle pulse starting a load (sampled only in IDLE)
//   Load_Len   number of words to load (saturated to the memory depth)
//   In_Valid   byte-stream valid
//   In_Data    byte-stream data
//   In_Ready   byte accepted when In_Valid && In_Ready
//   IM_We      instruction-memory write enable
//   IM_Addr    instruction-memory word address
//   IM_Wdata   instruction-memory write data
//   Cpu_Reset  active-high reset to the core
//   Busy       high in RECV, WRITE and CHECK
//   Done       one-cycle pulse when a load finishes
//   Chk_Err    sticky checksum-mismatch flag
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int START_ADDR = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Load_Start,
    input  logic [ADDR_WIDTH:0]   Load_Len,
    input  logic                  In_Valid,
    input  logic [7:0]            In_Data,
    output logic                  In_Ready,
    output logic                  IM_We,
    output logic [ADDR_WIDTH-1:0] IM_Addr,
    output logic [31:0]           IM_Wdata,
    output logic                  Cpu_Reset,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Chk_Err
);
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic                  booted_q, booted_d;
    logic                  accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
    logic                  chk_err_q, chk_err_d;
`endif

    assign In_Ready  = (state_q == S_RECV) || (state_q == S_CHECK);
    assign accept    = In_Valid && In_Ready;
    assign IM_We     = (state_q == S_WRITE);
    assign IM_Addr   = addr_q;
    assign IM_Wdata  = word_q;
    assign Busy      = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
    assign Done      = (state_q == S_DONE);
    // Any non-idle state is a load in progress, so the core is held in reset.
    assign Cpu_Reset = (state_q != S_IDLE) || !booted_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign Chk_Err   = chk_err_q;
`else
    assign Chk_Err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        booted_d   = booted_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        chk_err_d  = chk_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Load_Start) begin
                    // Any length with the top bit set is at least the depth.
                    len_d      = Load_Len[ADDR_WIDTH] ? DEPTH : Load_Len;
                    addr_d     = START;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    booted_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    chk_err_d  = 1'b0;
`endif
                    state_d    = (len_d == '0) ? S_TAIL : S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    word_d     = {word_q[23:0], In_Data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = (byte_cnt_q == 2'd3) ? S_WRITE : S_RECV;
                end
            end
            S_WRITE: begin
                addr_d     = addr_q + ADDR_WIDTH'(1);
                word_cnt_d = word_cnt_q + (ADDR_WIDTH+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d      = sum_q + word_q;
`endif
                state_d    = (word_cnt_d == len_q) ? S_TAIL : S_RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    word_d     = {word_q[23:0], In_Data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        chk_err_d = ({word_q[23:0], In_Data} != sum_q);
                        state_d   = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                booted_d = !chk_err_q;
`else
                booted_d = 1'b1;
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            booted_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            booted_q   <= booted_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
    localparam int AW    = 3;
    localparam int SA    = 6;
    localparam int DEPTH = 1 << AW;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Load_Start = 1'b0;
    logic [AW:0]   Load_Len = '0;
    logic          In_Valid = 1'b0;
    logic [7:0]    In_Data = '0;
    logic          In_Ready, IM_We, Cpu_Reset, Busy, Done, Chk_Err;
    logic [AW-1:0] IM_Addr;
    logic [31:0]   IM_Wdata;

    imem_loader #(.ADDR_WIDTH(AW), .START_ADDR(SA)) dut (
        .Clk(Clk), .Reset(Reset), .Load_Start(Load_Start), .Load_Len(Load_Len),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .IM_We(IM_We), .IM_Addr(IM_Addr), .IM_Wdata(IM_Wdata),
        .Cpu_Reset(Cpu_Reset), .Busy(Busy), .Done(Done), .Chk_Err(Chk_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset && IM_We) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data %h, expected no write", IM_Addr, IM_Wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(IM_Addr), 32'(e.a));
                check("wr_data", IM_Wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke, input bit rdy_chk);
        bit r;
        int cnt;
        for (int i = 0; i < gap; i++) begin
            Load_Start = poke && (i == 0);
            Load_Len   = 1;
            @(negedge Clk);
            if (rdy_chk) check("gap_ready", 32'(In_Ready), 32'd1);
            @(posedge Clk);
            #1;
        end
        Load_Start = 1'b0;
        In_Valid   = 1'b1;
        In_Data    = b;
        cnt        = 0;
        r          = 1'b0;
        while (!r && cnt < 50) begin
            @(negedge Clk);
            r = In_Ready;
            @(posedge Clk);
            #1;
            cnt++;
        end
        if (!r) check("byte_timeout", 32'd0, 32'd1);
        In_Valid = 1'b0;
    endtask

    task automatic do_load(input int n_req, input int maxgap, input int gap_at, input bit poke, input bit corrupt);
        int          n;
        int          lat;
        bit          seen;
        bit          exp_err;
        logic [31:0] sum;
        logic [31:0] w;
        wr_t         e;
        n   = (n_req > DEPTH) ? DEPTH : n_req;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            e.a = AW'(SA + i);
            e.d = words[i];
            exp_q.push_back(e);
            sum += words[i];
        end
        Load_Len   = (AW+1)'(n_req);
        Load_Start = 1'b1;
        @(posedge Clk);
        #1;
        Load_Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                int idx;
                int gap;
                idx = i * 4 + k;
                gap = (idx == gap_at) ? 7 : $urandom_range(0, maxgap);
                if (poke && idx == 1 && gap == 0) gap = 1;
                send_byte(w[31-8*k -: 8], gap, poke && idx == 1, idx == gap_at);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        w = corrupt ? sum + 32'd1 : sum;
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], $urandom_range(0, maxgap), 1'b0, 1'b0);
        exp_err = corrupt;
        lat = 0;
        seen = 0;
        while (!seen && lat < 6) begin
            @(negedge Clk);
            lat++;
            seen = Done;
        end
        check("done_latency", lat, 1);
`else
        exp_err = 1'b0;
        lat = 0;
        seen = 0;
        while (!seen && lat < 6) begin
            @(negedge Clk);
            lat++;
            seen = Done;
        end
        check("done_latency", lat, (n == 0) ? 1 : 2);
`endif
        check("done_cpu_reset", 32'(Cpu_Reset), 32'd1);
        @(negedge Clk);
        check("done_pulse_width", 32'(Done), 32'd0);
        check("after_cpu_reset", 32'(Cpu_Reset), 32'(exp_err));
        check("after_chk_err", 32'(Chk_Err), 32'(exp_err));
        check("after_busy", 32'(Busy), 32'd0);
        check("pending_writes", exp_q.size(), 0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Load_Len = 5;
        #15;
        check("rst_cpu_reset", 32'(Cpu_Reset), 32'd1);
        check("rst_in_ready", 32'(In_Ready), 32'd0);
        check("rst_we", 32'(IM_We), 32'd0);
        check("rst_addr", 32'(IM_Addr), 32'd0);
        check("rst_wdata", IM_Wdata, 32'd0);
        check("rst_busy_done_err", {29'd0, Busy, Done, Chk_Err}, 32'd0);
        #5;
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("idle_busy", 32'(Busy), 32'd0);
            check("idle_in_ready", 32'(In_Ready), 32'd0);
            check("idle_cpu_reset", 32'(Cpu_Reset), 32'd1);
        end
        @(posedge Clk);
        #1;

        words = '{32'h20080005, 32'hAC020000};
        do_load(2, 0, -1, 1'b0, 1'b0);
        do_load(2, 0, 2, 1'b0, 1'b0);
        words = '{};
        do_load(0, 0, -1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{32'h00000001, 32'hFFFFFFFF};
        do_load(2, 1, -1, 1'b0, 1'b0);
        do_load(2, 1, -1, 1'b0, 1'b1);
`endif

        for (int it = 0; it < 10; it++) begin
            int n;
            n = (it == 0) ? 11 : (it == 1) ? 8 : $urandom_range(0, 11);
            words = '{};
            for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
            do_load(n, 2, -1, (it % 3) == 0, (it % 4) == 1);
        end

        words = '{$urandom, $urandom, $urandom};
        begin
            wr_t e;
            e.a = AW'(SA);
            e.d = words[0];
            exp_q.push_back(e);
        end
        Load_Len   = 3;
        Load_Start = 1'b1;
        @(posedge Clk);
        #1;
        Load_Start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            logic [31:0] w;
            w = words[b / 4];
            send_byte(w[31-8*(b%4) -: 8], $urandom_range(0, 1), 1'b0, 1'b0);
        end
        #2;
        Reset = 1'b0;
        #1;
        check("abort_cpu_reset", 32'(Cpu_Reset), 32'd1);
        check("abort_we", 32'(IM_We), 32'd0);
        check("abort_in_ready", 32'(In_Ready), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("abort_hold_cpu_reset", 32'(Cpu_Reset), 32'd1);
            check("abort_hold_busy", 32'(Busy), 32'd0);
        end
        check("abort_writes", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
